// File: rtl/fts_arb.sv
// Round-robin arbiter that feeds one shared fast-to-slow synchronizer channel.
// Each accepted word is held on tx_data for HOLD fast cycles and flagged by a toggle flip.
module fts_arb #(
    parameter int unsigned N    = 2,
    parameter int unsigned NREQ = 4,
    parameter int unsigned HOLD = 24,
    parameter int unsigned SW   = $clog2(NREQ)
) (
    input  logic                fastclk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [N-1:0]        tx_data,
    output logic [SW-1:0]       tx_src,
    output logic                tx_toggle,
    output logic                busy
);

    localparam int unsigned CW = $clog2(HOLD + 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   win;
    logic            found;
    logic            accept;

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        logic [SW-1:0] cand;
        found = 1'b0;
        win   = ptr;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = SW'((32'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        accept    = 1'b0;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                accept = found && rst_n;
                if (accept) begin
                    req_ready[win] = 1'b1;
                    state_nx       = ST_HOLD;
                    cnt_nx         = CW'(HOLD);
                end
            end
            ST_HOLD: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= SW'(NREQ - 1);
            tx_data   <= '0;
            tx_src    <= '0;
            tx_toggle <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            busy  <= (state_nx == ST_HOLD);
            if (accept) begin
                tx_data   <= req_data[win*N +: N];
                tx_src    <= win;
                tx_toggle <= ~tx_toggle;
                ptr       <= win;
            end
        end
    end

endmodule

// File: tb/tb_fts_arb.sv
// Directed bench for fts_arb: reset, single accept, fairness, late request, reset mid-hold.
module tb_fts_arb;

    localparam int unsigned N    = 2;
    localparam int unsigned NREQ = 4;
    localparam int unsigned HOLD = 24;
    localparam int unsigned SW   = 2;

    logic              fastclk = 1'b0;
    logic              rst_n   = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      tx_data;
    logic [SW-1:0]     tx_src;
    logic              tx_toggle;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    logic exp_tog = 1'b0;

    fts_arb #(.N(N), .NREQ(NREQ), .HOLD(HOLD), .SW(SW)) dut (
        .fastclk  (fastclk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx_data  (tx_data),
        .tx_src   (tx_src),
        .tx_toggle(tx_toggle),
        .busy     (busy)
    );

    always #2 fastclk = ~fastclk;

    // Advance to the next falling edge, one rising edge after the previous sample.
    task automatic step();
        @(negedge fastclk);
        edge_n++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (3) step();
        total++; if ({tx_data, tx_src, tx_toggle, busy, req_ready} !== '0) begin
            bad++; $display("FAIL reset_hold outs=%h required 0", {tx_data, tx_src, tx_toggle, busy, req_ready});
        end
        rst_n = 1'b1;
        repeat (3) step();
        total++; if ({tx_data, tx_src, tx_toggle, busy, req_ready} !== '0) begin
            bad++; $display("FAIL reset_release outs=%h required 0", {tx_data, tx_src, tx_toggle, busy, req_ready});
        end
        exp_tog = 1'b0;
    endtask

    task automatic test_single();
        int bcnt;
        req_data  = 8'b00_11_00_00;
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL single_ready got=%b required 0100", req_ready);
        end
        step();
        req_valid = '0;
        exp_tog = ~exp_tog;
        total++; if (tx_data !== 2'b11) begin
            bad++; $display("FAIL single_data got=%b required 11", tx_data);
        end
        total++; if (tx_src !== 2'd2) begin
            bad++; $display("FAIL single_src got=%0d required 2", tx_src);
        end
        total++; if (tx_toggle !== exp_tog) begin
            bad++; $display("FAIL single_toggle got=%b required %b", tx_toggle, exp_tog);
        end
        total++; if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL single_ready_drop got=%b required 0000", req_ready);
        end
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            bcnt++;
            step();
        end
        total++; if (bcnt != 24) begin
            bad++; $display("FAIL single_busy_len got=%0d required 24", bcnt);
        end
    endtask

    task automatic test_fairness();
        int last;
        int waited;
        int exp;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_tog = 1'b0;
        last = 0;
        req_data  = 8'b11_10_01_00;
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp = g % 4;
            waited = 0;
            while (req_ready === 4'b0000 && waited < 60) begin
                step();
                waited++;
            end
            total++; if (req_ready !== 4'(1 << exp)) begin
                bad++; $display("FAIL fair_ready[%0d] got=%b required %b waited=%0d", g, req_ready, 4'(1 << exp), waited);
            end
            if (g > 0) begin
                total++; if (edge_n - last != 25) begin
                    bad++; $display("FAIL fair_spacing[%0d] got=%0d required 25", g, edge_n - last);
                end
            end
            last = edge_n;
            step();
            exp_tog = ~exp_tog;
            total++; if (tx_src !== SW'(exp) || tx_data !== N'(exp) || tx_toggle !== exp_tog) begin
                bad++; $display("FAIL fair_tx[%0d] src=%0d data=%0d tog=%b required src=%0d data=%0d tog=%b",
                                g, tx_src, tx_data, tx_toggle, exp, exp, exp_tog);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_hold_request();
        int j;
        int changes;
        int early;
        while (busy === 1'b1 && j < 60) begin
            step();
            j++;
        end
        req_data  = 8'b10_00_01_00;
        req_valid = 4'b1000;
        #1;
        total++; if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL late_first_ready got=%b required 1000", req_ready);
        end
        step();
        req_valid = '0;
        exp_tog = ~exp_tog;
        total++; if (tx_data !== 2'b10 || tx_src !== 2'd3) begin
            bad++; $display("FAIL late_first_tx data=%b src=%0d required data=10 src=3", tx_data, tx_src);
        end
        j = 0;
        changes = 0;
        early = 0;
        while (j < 5) begin
            step();
            j++;
        end
        req_valid = 4'b0010;
        #1;
        while (req_ready === 4'b0000 && j < 60) begin
            if (tx_data !== 2'b10) changes++;
            step();
            j++;
        end
        total++; if (changes != 0) begin
            bad++; $display("FAIL late_hold_stable changes=%0d required 0", changes);
        end
        total++; if (j != 24) begin
            bad++; $display("FAIL late_ready_time got=%0d required 24", j);
        end
        total++; if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL late_ready got=%b required 0010", req_ready);
        end
        step();
        req_valid = '0;
        exp_tog = ~exp_tog;
        total++; if (tx_data !== 2'b01 || tx_src !== 2'd1 || tx_toggle !== exp_tog) begin
            bad++; $display("FAIL late_second_tx data=%b src=%0d tog=%b required 01/1/%b", tx_data, tx_src, tx_toggle, exp_tog);
        end
    endtask

    task automatic test_reset_mid_hold();
        int w;
        w = 0;
        while (busy === 1'b1 && w < 60) begin
            step();
            w++;
        end
        req_data  = 8'b11_00_00_01;
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL midrst_first_ready got=%b required 1000", req_ready);
        end
        step();
        repeat (10) step();
        total++; if (busy !== 1'b1 || tx_src !== 2'd3) begin
            bad++; $display("FAIL midrst_in_hold busy=%b src=%0d required 1/3", busy, tx_src);
        end
        rst_n = 1'b0;
        #1;
        total++; if ({tx_data, tx_src, tx_toggle, busy, req_ready} !== '0) begin
            bad++; $display("FAIL midrst_async outs=%h required 0", {tx_data, tx_src, tx_toggle, busy, req_ready});
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL midrst_restart_ready got=%b required 0001", req_ready);
        end
        step();
        req_valid = '0;
        total++; if (tx_src !== 2'd0 || tx_data !== 2'b01 || tx_toggle !== 1'b1) begin
            bad++; $display("FAIL midrst_restart_tx src=%0d data=%b tog=%b required 0/01/1", tx_src, tx_data, tx_toggle);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_hold_request();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
